// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: a word array split into byte lanes,
// accessed a fixed number of cycles after request acceptance, answered over valid/ready.
module data_mem_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int LATENCY       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                     state_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic                       we_reg;
  logic [ADDRESS_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]      wdata_reg;
  logic [BYTES-1:0]           be_reg;
  logic                       rsp_valid_reg;
  logic                       rsp_err_reg;
  logic                       load_ok_reg;

  logic                       misaligned;
  logic                       out_of_range;
  logic                       access_err;
  logic                       access;
  logic [IDX_W-1:0]           idx;

  genvar gi;

  if (OFF_W > 0) begin : g_align
    assign misaligned = |addr_reg[OFF_W-1:0];
  end else begin : g_no_align
    assign misaligned = 1'b0;
  end

  // Any set bit above the word index means the word lies beyond the array.
  if (OFF_W + IDX_W < ADDRESS_WIDTH) begin : g_range
    assign out_of_range = |addr_reg[ADDRESS_WIDTH-1:OFF_W+IDX_W];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  assign idx        = addr_reg[OFF_W +: IDX_W];
  assign access_err = misaligned | out_of_range;
  assign access     = (state_reg == BUSY) && (cnt_reg == '0);
  assign req_ready  = (state_reg == IDLE);
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_err    = rsp_err_reg;

  // One array per byte lane keeps byte-enabled writes single-driver and RAM-friendly.
  for (gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_rd_reg;

    always_ff @(posedge clk) begin
      if (access && !access_err) begin
        if (we_reg && be_reg[gi]) begin
          lane_mem[idx] <= wdata_reg[8*gi +: 8];
        end
        lane_rd_reg <= lane_mem[idx];
      end
    end

    assign rsp_rdata[8*gi +: 8] = load_ok_reg ? lane_rd_reg : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      load_ok_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
            cnt_reg   <= CNT_W'(LATENCY - 1);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= access_err;
            load_ok_reg   <= !we_reg && !access_err;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset corner cases and
// randomized traffic checked against a byte-level array model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [16];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  data_mem_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected response from the array model; updates the model for in-range stores.
  task automatic model_apply(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] exp_rd, output logic exp_err);
    int w;
    exp_rd  = 32'h0;
    exp_err = (a % 4 != 0) || (a / 4 >= 32'(DEPTH));
    if (!exp_err) begin
      w = int'(a / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[w][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = model_mem[w];
      end
    end
  endtask

  // Present one request and return just after its acceptance edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic noise);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'h1);
    req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (noise) begin
      // a stray store held while busy must never be taken
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    end else begin
      req_valid = 1'b0;
    end
    chk("req_ready_busy", 32'(req_ready), 32'h0);
    chk("rsp_valid_early", 32'(rsp_valid), 32'h0);
  endtask

  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input int delay, input logic noise,
                         output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    model_apply(we, a, wd, be, exp_rd, exp_err);
    issue(we, a, wd, be, noise);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 50);
    chk("latency", 32'(lat), 32'(LAT));
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", 32'(rsp_err), 32'(exp_err));
    chk("req_ready_resp", 32'(req_ready), 32'h0);
    rd = rsp_rdata;
    er = rsp_err;
    for (int k = 0; k < delay; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", 32'(rsp_err), 32'(er));
      chk("hold_req_ready", 32'(req_ready), 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("valid_after_hs", 32'(rsp_valid), 32'h0);
    chk("ready_after_hs", 32'(req_ready), 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          lat;

    vecs[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'h10,   32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h10,   32'h11223344, 4'b0101, 32'h0,        1'b0};
    vecs[3] = '{1'b0, 32'h10,   32'h0,        4'h0,    32'hDE22BE44, 1'b0};
    vecs[4] = '{1'b0, 32'h13,   32'h0,        4'h0,    32'h0,        1'b1};
    vecs[5] = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1};
    vecs[6] = '{1'b0, 32'h0,    32'h0,        4'h0,    32'h0,        1'b0};
    vecs[7] = '{1'b1, 32'h14,   32'h12345678, 4'h0,    32'h0,        1'b0};
    vecs[8] = '{1'b0, 32'h14,   32'h0,        4'h0,    32'h0,        1'b0};
    vecs[9] = '{1'b1, 32'h3FFE, 32'h0,        4'hF,    32'h0,        1'b1};
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;

    // reset applies without any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < 16; w++) run_txn(1'b1, 32'(w * 4), 32'h0, 4'hF, 0, 1'b0, rd, er);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, i % 2, 1'b0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // backpressure with a stray request held high while busy
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, rd, er);
    chk("bp_rdata", rd, 32'hDE22BE44);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("bp_no_stray_write", rd, 32'hDE22BE44);

    // mid-cycle reset while a response is pending
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    repeat (LAT) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rdata", rsp_rdata, 32'h0);
    chk("midrst_err", 32'(rsp_err), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // reset before commit drops the store
    issue(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("abort_store_dropped", rd, 32'h0);

    // reset after commit keeps the store
    issue(1'b1, 32'h24, 32'h5A5A1234, 4'hF, 1'b0);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("commit_latency", 32'(lat), 32'(LAT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_mem[9] = 32'h5A5A1234;
    run_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("committed_store_kept", rd, 32'h5A5A1234);

    for (int n = 0; n < 150; n++) begin
      int sel;
      int w;
      w   = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 9));
      a   = 32'(w * 4);
      if (sel == 0) a = a + 32'($urandom_range(1, 3));
      else if (sel == 1) a = a + 32'h1000;
      run_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
